// File: rtl/ram_burst_reader.sv
// Burst read initiator for the single-port synchronous RAM.
// Streams a contiguous run of words out over valid/ready through a 3-entry skid FIFO.
module ram_burst_reader #(
   parameter int dWidth = 8,
   parameter int aWidth = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [aWidth-1:0] base_addr,
   input  logic [aWidth-1:0] len,
   input  logic              abort,
   output logic [aWidth-1:0] ram_addr,
   output logic              ram_cs,
   output logic              ram_we,
   input  logic [dWidth-1:0] ram_q,
   output logic [dWidth-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [aWidth-1:0] r_addr;
   logic [aWidth-1:0] r_len;
   logic [aWidth-1:0] r_issue_cnt;
   logic [aWidth-1:0] r_out_cnt;
   logic              r_inflight;
   logic              r_done;

   logic [dWidth-1:0] r_fifo [0:2];
   logic [1:0]        r_wptr;
   logic [1:0]        r_rptr;
   logic [1:0]        r_count;

   logic              w_start_ok;
   logic              w_abort;
   logic              w_room;
   logic              w_issue;
   logic              w_last_issue;
   logic              w_valid;
   logic              w_pop;
   logic              w_push;
   logic              w_last;
   logic              w_finish;
   logic [2:0]        w_pending;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   assign w_start_ok   = (r_state == IDLE) & start & ~abort;
   assign w_abort      = (r_state != IDLE) & abort;
   assign w_pending    = {1'b0, r_count} + {2'b00, r_inflight};
   assign w_room       = (w_pending < 3'd3);
   // An aborting cycle issues nothing so no stray read follows the abort.
   assign w_issue      = (r_state == RUN) & w_room & ~abort;
   assign w_last_issue = w_issue & (r_issue_cnt == r_len);
   assign w_valid      = (r_count != 2'd0);
   assign w_pop        = w_valid & out_ready;
   assign w_push       = r_inflight & ~w_abort;
   assign w_last       = w_valid & (r_out_cnt == r_len);
   assign w_finish     = w_pop & w_last;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_start_ok) begin
               w_next = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               w_next = IDLE;
            end else if (w_last_issue) begin
               w_next = DRAIN;
            end
         end
         DRAIN: begin
            if (abort || w_finish) begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Output logic
   always_comb begin
      ram_cs    = w_issue;
      ram_addr  = r_addr;
      ram_we    = 1'b0;
      busy      = (r_state != IDLE);
      out_valid = w_valid;
      out_data  = r_fifo[r_rptr];
      out_last  = w_last;
      done      = r_done;
   end

   // Address, length and counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr      <= '0;
         r_len       <= '0;
         r_issue_cnt <= '0;
         r_out_cnt   <= '0;
         r_inflight  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         r_done     <= (r_state == DRAIN) & w_finish & ~abort;
         if (w_start_ok) begin
            r_addr      <= base_addr;
            r_len       <= len;
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
         end else begin
            if (w_issue) begin
               r_addr      <= r_addr + 1'b1;
               r_issue_cnt <= r_issue_cnt + 1'b1;
            end
            if (w_pop) begin
               r_out_cnt <= r_out_cnt + 1'b1;
            end
         end
      end
   end

   // Skid FIFO: read data lands here one cycle after each issue
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 3; i++) begin
            r_fifo[i] <= '0;
         end
         r_wptr  <= 2'd0;
         r_rptr  <= 2'd0;
         r_count <= 2'd0;
      end else if (w_abort) begin
         r_wptr  <= 2'd0;
         r_rptr  <= 2'd0;
         r_count <= 2'd0;
      end else begin
         if (w_push) begin
            r_fifo[r_wptr] <= ram_q;
            r_wptr         <= ptr_inc(r_wptr);
         end
         if (w_pop) begin
            r_rptr <= ptr_inc(r_rptr);
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

endmodule
